// File: rtl/alu_operand_stage_if.sv
// Instruction request and alu operand/result bundle between a sequencer and the
// operand stage. The master side issues instructions and hosts the combinational alu.
interface alu_operand_stage_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned OP_W      = 3
);
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  logic                  req_valid;
  logic                  req_ready;
  logic [OP_W-1:0]       req_op;
  logic [REG_ADDR_W-1:0] req_rx;
  logic [REG_ADDR_W-1:0] req_ry;
  logic [WORD_SIZE-1:0]  alu_a;
  logic [WORD_SIZE-1:0]  alu_b;
  logic [OP_W-1:0]       alu_op;
  logic [WORD_SIZE-1:0]  alu_res;

  modport master (
    output req_valid, req_op, req_rx, req_ry, alu_res,
    input  req_ready, alu_a, alu_b, alu_op
  );

  modport slave (
    input  req_valid, req_op, req_rx, req_ry, alu_res,
    output req_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand/writeback stage around a combinational alu: register bank, one instruction
// in flight, IDLE -> FETCH -> EXEC -> WB, result written back to R[rx] with Z/N flags.
module alu_operand_stage #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned OP_W      = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  alu_operand_stage_if.slave                   bus,
  input  logic                                 ext_we_i,
  input  logic [$clog2(NUM_REGS)-1:0]          ext_addr_i,
  input  logic [WORD_SIZE-1:0]                 ext_wdata_i,
  output logic [WORD_SIZE-1:0]                 ext_rdata_o,
  output logic                                 flag_z_o,
  output logic                                 flag_n_o,
  output logic                                 done_o
);

  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StWb    = 2'd3;

  localparam logic [OP_W-1:0] OpAdd = '0;

  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("NUM_REGS must be a power of two and at least 2");
  end

  logic [1:0]            state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [REG_ADDR_W-1:0] rx_q, rx_d;
  logic [REG_ADDR_W-1:0] ry_q, ry_d;
  logic [WORD_SIZE-1:0]  alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0]  alu_b_q, alu_b_d;
  logic [OP_W-1:0]       alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0]  res_q, res_d;
  logic                  flag_z_q, flag_z_d;
  logic                  flag_n_q, flag_n_d;
  logic [WORD_SIZE-1:0]  regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]  regs_d [NUM_REGS];

  logic in_idle;
  logic handshake;

  assign in_idle   = (state_q == StIdle);
  assign handshake = bus.req_valid & bus.req_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          op_d    = bus.req_op;
          rx_d    = bus.req_rx;
          ry_d    = bus.req_ry;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Reads regs_q, so an external load on the accept edge is already visible.
        alu_a_d  = regs_q[rx_q];
        alu_b_d  = regs_q[ry_q];
        alu_op_d = op_q;
        state_d  = StExec;
      end
      StExec: begin
        res_d   = bus.alu_res;
        state_d = StWb;
      end
      StWb: begin
        flag_z_d = (res_q == '0);
        flag_n_d = res_q[WORD_SIZE-1];
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // External loads only in IDLE; writeback only in WB, so the two never collide.
  always_comb begin
    regs_d = regs_q;
    if (in_idle && ext_we_i) begin
      regs_d[ext_addr_i] = ext_wdata_i;
    end
    if (state_q == StWb) begin
      regs_d[rx_q] = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      rx_q     <= '0;
      ry_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OpAdd;
      res_q    <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.req_ready = in_idle & ~rst;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign ext_rdata_o   = regs_q[ext_addr_i];
  assign flag_z_o      = flag_z_q;
  assign flag_n_o      = flag_n_q;
  assign done_o        = (state_q == StWb);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: hosts a behavioural alu and checks
// writebacks against a register model through a scoreboard queue.
module tb_alu_operand_stage;

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned OW = 3;
  localparam int unsigned AW = 3;

  localparam logic [OW-1:0] OP_ADD = 3'd0;
  localparam logic [OW-1:0] OP_SUB = 3'd1;
  localparam logic [OW-1:0] OP_AND = 3'd2;
  localparam logic [OW-1:0] OP_OR  = 3'd3;
  localparam logic [OW-1:0] OP_XOR = 3'd4;
  localparam logic [OW-1:0] OP_EQ  = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [W-1:0]  ext_wdata;
  logic [W-1:0]  ext_rdata;
  logic          flag_z;
  logic          flag_n;
  logic          done;

  alu_operand_stage_if #(.WORD_SIZE(W), .NUM_REGS(NR), .OP_W(OW)) bus ();

  alu_operand_stage #(.WORD_SIZE(W), .NUM_REGS(NR), .OP_W(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ext_we_i    (ext_we),
    .ext_addr_i  (ext_addr),
    .ext_wdata_i (ext_wdata),
    .ext_rdata_o (ext_rdata),
    .flag_z_o    (flag_z),
    .flag_n_o    (flag_n),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_EQ:   return (a == b) ? 16'd1 : 16'd0;
      default: return a;
    endcase
  endfunction

  assign bus.alu_res = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  typedef struct {
    logic [AW-1:0] rx;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  res;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_regs [NR];
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    tick();
    ext_we = 1'b0;
    m_regs[a] = d;
  endtask

  // Caller must be in IDLE; returns just after the accept edge (FETCH cycle).
  task automatic op_start(input logic [OW-1:0] op, input logic [AW-1:0] rx,
                          input logic [AW-1:0] ry, input bit ew, input logic [AW-1:0] ea,
                          input logic [W-1:0] ed);
    exp_t e;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_rx = rx; bus.req_ry = ry;
    ext_we = ew; ext_addr = ea; ext_wdata = ed;
    tick();
    bus.req_valid = 1'b0; ext_we = 1'b0;
    if (ew) m_regs[ea] = ed;
    e.rx = rx; e.a = m_regs[rx]; e.b = m_regs[ry]; e.res = alu_f(op, e.a, e.b);
    m_regs[rx] = e.res;
    sb.push_back(e);
  endtask

  task automatic finish_op(input string name, input bit ext_busy);
    exp_t e;
    int   cyc;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s sb_empty: got empty queue, required one entry", name);
      return;
    end
    e = sb.pop_front();
    cyc = 0;
    for (int i = 1; i <= 8 && cyc == 0; i++) begin
      @(negedge clk);
      if (ext_busy && i == 1) begin
        ext_we = 1'b1; ext_addr = 3'd5; ext_wdata = 16'h1234;
      end
      if (ext_busy && i == 3) ext_we = 1'b0;
      if (i == 2) begin
        n_total++;
        if (bus.alu_a !== e.a || bus.alu_b !== e.b)
          $display("FAIL %s operands: got a=%h b=%h, required a=%h b=%h", name, bus.alu_a,
                   bus.alu_b, e.a, e.b);
        else n_pass++;
      end
      if (done) cyc = i;
    end
    ext_we = 1'b0;
    n_total++;
    if (cyc !== 3) $display("FAIL %s latency: got %0d cycles, required 3", name, cyc);
    else n_pass++;
    tick();
    ext_addr = e.rx;
    #1;
    n_total++;
    if (ext_rdata !== e.res) $display("FAIL %s wb: got %h, required %h", name, ext_rdata, e.res);
    else n_pass++;
    n_total++;
    if (flag_z !== (e.res == 0) || flag_n !== e.res[W-1] || done !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL %s flags: got z=%b n=%b done=%b rdy=%b, required z=%b n=%b done=0 rdy=1",
               name, flag_z, flag_n, done, bus.req_ready, e.res == 0, e.res[W-1]);
    else n_pass++;
  endtask

  task automatic check_reg(input string name, input logic [AW-1:0] a, input logic [W-1:0] want);
    ext_addr = a;
    #1;
    n_total++;
    if (ext_rdata !== want) $display("FAIL %s: got %h, required %h", name, ext_rdata, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    bus.req_valid = 1'b0; bus.req_op = OP_ADD; bus.req_rx = '0; bus.req_ry = '0;
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus.req_ready !== 1'b0) $display("FAIL rst_ready_low: got %b, required 0", bus.req_ready);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < int'(NR); i++) check_reg("rst_reg", AW'(i), 16'h0000);
    n_total++;
    if (bus.req_ready !== 1'b1 || flag_z !== 1'b0 || flag_n !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_state: got rdy=%b z=%b n=%b done=%b, required 1 0 0 0",
               bus.req_ready, flag_z, flag_n, done);
    else n_pass++;
    n_total++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_op !== OP_ADD)
      $display("FAIL rst_alu: got a=%h b=%h op=%0d, required 0 0 0", bus.alu_a, bus.alu_b,
               bus.alu_op);
    else n_pass++;
    tick();
  endtask

  task automatic test_add();
    ext_write(3'd1, 16'h0005);
    ext_write(3'd2, 16'h0003);
    op_start(OP_ADD, 3'd1, 3'd2, 1'b0, '0, '0);
    finish_op("add", 1'b0);
    check_reg("add_r1", 3'd1, 16'h0008);
  endtask

  task automatic test_flags();
    ext_write(3'd3, 16'h0003);
    op_start(OP_SUB, 3'd3, 3'd3, 1'b0, '0, '0);
    finish_op("sub_zero", 1'b0);
    check_reg("sub_zero_r3", 3'd3, 16'h0000);
    n_total++;
    if (flag_z !== 1'b1) $display("FAIL sub_zero_z: got %b, required 1", flag_z);
    else n_pass++;
    ext_write(3'd1, 16'h0000);
    op_start(OP_SUB, 3'd1, 3'd2, 1'b0, '0, '0);
    finish_op("sub_neg", 1'b0);
    check_reg("sub_neg_r1", 3'd1, 16'hFFFD);
    n_total++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0)
      $display("FAIL sub_neg_flags: got n=%b z=%b, required n=1 z=0", flag_n, flag_z);
    else n_pass++;
    op_start(OP_EQ, 3'd4, 3'd2, 1'b0, '0, '0);
    finish_op("eq_false", 1'b0);
    op_start(OP_EQ, 3'd3, 3'd3, 1'b0, '0, '0);
    finish_op("eq_true", 1'b0);
    check_reg("eq_true_r3", 3'd3, 16'h0001);
    op_start(OP_XOR, 3'd1, 3'd3, 1'b0, '0, '0);
    finish_op("xor", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [11:0] rmask;
    logic [11:0] dmask;
    int          acc;
    int          dones;
    exp_t        e;
    ext_write(3'd1, 16'h0000);
    ext_write(3'd2, 16'h0002);
    rmask = '0; dmask = '0; acc = 0;
    bus.req_valid = 1'b1; bus.req_op = OP_ADD; bus.req_rx = 3'd1; bus.req_ry = 3'd2;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        rmask[c] = 1'b1;
        acc++;
        e.rx = 3'd1; e.a = m_regs[1]; e.b = m_regs[2]; e.res = alu_f(OP_ADD, e.a, e.b);
        m_regs[1] = e.res;
        sb.push_back(e);
      end
      if (done) begin
        dmask[c] = 1'b1;
        n_total++;
        if (sb.size() == 0) $display("FAIL b2b_pop: got empty queue, required entry");
        else begin
          e = sb.pop_front();
          if (bus.alu_a !== e.a || bus.alu_b !== e.b)
            $display("FAIL b2b_operands: got a=%h b=%h, required a=%h b=%h", bus.alu_a,
                     bus.alu_b, e.a, e.b);
          else n_pass++;
        end
      end
      tick();
      if (acc == 3) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    n_total++;
    if (rmask !== 12'h111) $display("FAIL b2b_accepts: got %h, required 111", rmask);
    else n_pass++;
    n_total++;
    if (dmask !== 12'h888) $display("FAIL b2b_dones: got %h, required 888", dmask);
    else n_pass++;
    check_reg("b2b_r1", 3'd1, 16'h0006);

    // A request offered only during EXEC must be dropped.
    op_start(OP_ADD, 3'd1, 3'd2, 1'b0, '0, '0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (sb.size() != 0) e = sb.pop_front();
      end
      tick();
      bus.req_valid = (i == 0);
    end
    bus.req_valid = 1'b0;
    n_total++;
    if (dones !== 1) $display("FAIL exec_drop_dones: got %0d, required 1", dones);
    else n_pass++;
    check_reg("exec_drop_r1", 3'd1, 16'h0008);
  endtask

  task automatic test_ext_write();
    ext_write(3'd1, 16'h0001);
    op_start(OP_ADD, 3'd1, 3'd2, 1'b1, 3'd2, 16'h0010);
    finish_op("ext_same_edge", 1'b0);
    check_reg("ext_same_edge_r1", 3'd1, 16'h0011);
    check_reg("ext_same_edge_r2", 3'd2, 16'h0010);
    ext_write(3'd4, 16'h0000);
    op_start(OP_AND, 3'd4, 3'd4, 1'b0, '0, '0);
    finish_op("ext_in_exec", 1'b1);
    check_reg("ext_in_exec_r5", 3'd5, 16'h0000);
  endtask

  task automatic test_abort();
    int dones;
    ext_write(3'd6, 16'h0007);
    ext_write(3'd7, 16'h0002);
    op_start(OP_ADD, 3'd6, 3'd7, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    #1;
    n_total++;
    if (done !== 1'b0 || bus.req_ready !== 1'b0)
      $display("FAIL abort_in_rst: got done=%b rdy=%b, required 0 0", done, bus.req_ready);
    else n_pass++;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 0) begin
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL abort_ready: got %b, required 1", bus.req_ready);
        else n_pass++;
      end
    end
    n_total++;
    if (dones !== 0) $display("FAIL abort_done: got %0d pulses, required 0", dones);
    else n_pass++;
    check_reg("abort_r6", 3'd6, 16'h0000);
    n_total++;
    if (flag_z !== 1'b0 || flag_n !== 1'b0)
      $display("FAIL abort_flags: got z=%b n=%b, required 0 0", flag_z, flag_n);
    else n_pass++;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_back_to_back();
    test_ext_write();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
